zap_memory_main: RTL and testbench

- Memory stage of ZAP; sits directly upstream of the register file (writeback).
- Registers ALU-stage results and load data from the data bus, aligns and extends load data, converts bus aborts into a data-abort indication, and emits bubbles during data stalls.
- Flushes on writeback clears.
- Its registered outputs drive the register file's valid, write-port, flag, load, exception and PC+8 inputs one-for-one.

---
 rtl/zap_memory_main_pkg.sv | 12 +
 rtl/zap_memory_main_load_align.sv | 37 +++
 rtl/zap_memory_main.sv | 111 +++++++++++
 tb/tb_zap_memory_main.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/zap_memory_main_pkg.sv
// rtl/zap_memory_main_pkg.sv - shared constants for the ZAP memory stage
package zap_memory_main_pkg;

    localparam int PHY_REGS         = 46;
    localparam int IDX_W            = $clog2(PHY_REGS);
    localparam int PHY_RAZ_REGISTER = 45;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

endpackage

// File: rtl/zap_memory_main_load_align.sv
// rtl/zap_memory_main_load_align.sv - combinational load data alignment and extension
module zap_load_align
    import zap_memory_main_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_lsb,
    output logic [31:0] o_result
);

    logic [31:0] rot;
    logic [15:0] half;

    // Rotating right by the byte offset also brings the addressed byte lane to bits [7:0].
    always_comb begin
        rot = i_data;
        case (i_lsb)
            2'd1:    rot = {i_data[7:0],  i_data[31:8]};
            2'd2:    rot = {i_data[15:0], i_data[31:16]};
            2'd3:    rot = {i_data[23:0], i_data[31:24]};
            default: rot = i_data;
        endcase
    end

    assign half = i_lsb[1] ? i_data[31:16] : i_data[15:0];

    always_comb begin
        o_result = rot;
        case (i_size)
            MEM_BYTE: o_result = {{24{i_signed & rot[7]}}, rot[7:0]};
            MEM_HALF: o_result = {{16{i_signed & half[15]}}, half};
            default:  o_result = rot;
        endcase
    end

endmodule

// File: rtl/zap_memory_main.sv
// rtl/zap_memory_main.sv - ZAP memory stage: registers ALU results and aligned load data for writeback
module zap_memory_main
    import zap_memory_main_pkg::*;
#(
    parameter int PHY_REGS = zap_memory_main_pkg::PHY_REGS,
    parameter int FLAG_WDT = 32,
    localparam int IDX     = $clog2(PHY_REGS)
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_valid,
    input  logic [31:0]         i_alu_result,
    input  logic [IDX-1:0]      i_wr_index,
    input  logic [FLAG_WDT-1:0] i_flags,
    input  logic                i_flag_update,
    input  logic                i_mem_load,
    input  logic [IDX-1:0]      i_mem_srcdest_index,
    input  logic [1:0]          i_mem_size,
    input  logic                i_mem_signed,
    input  logic [1:0]          i_mem_addr_lsb,
    input  logic [31:0]         i_pc_plus_8,
    input  logic                i_irq,
    input  logic                i_fiq,
    input  logic                i_instr_abt,
    input  logic                i_swi,
    input  logic                i_und,
    input  logic [31:0]         i_data_rd,
    input  logic                i_data_stall,
    input  logic                i_data_abt,
    input  logic                i_clear_from_writeback,
    output logic                o_valid,
    output logic [IDX-1:0]      o_wr_index,
    output logic [31:0]         o_wr_data,
    output logic [FLAG_WDT-1:0] o_flags,
    output logic                o_flag_update_ff,
    output logic                o_mem_load_ff,
    output logic [IDX-1:0]      o_wr_index_1,
    output logic [31:0]         o_wr_data_1,
    output logic [31:0]         o_pc_buf_ff,
    output logic                o_irq,
    output logic                o_fiq,
    output logic                o_instr_abt,
    output logic                o_swi,
    output logic                o_und,
    output logic                o_data_abt
);

    localparam logic [IDX-1:0] RAZ_IDX = IDX'(PHY_RAZ_REGISTER);

    logic [31:0] aligned;
    logic        bubble;
    logic        load_abt;

    zap_load_align u_align (
        .i_data   (i_data_rd),
        .i_size   (i_mem_size),
        .i_signed (i_mem_signed),
        .i_lsb    (i_mem_addr_lsb),
        .o_result (aligned)
    );

    // Flush and stall share one enable: either one turns this cycle into a bubble with held data.
    assign bubble   = i_clear_from_writeback | i_data_stall;
    assign load_abt = i_valid & i_mem_load & i_data_abt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid          <= 1'b0;
            o_wr_index       <= RAZ_IDX;
            o_wr_data        <= '0;
            o_flags          <= '0;
            o_flag_update_ff <= 1'b0;
            o_mem_load_ff    <= 1'b0;
            o_wr_index_1     <= RAZ_IDX;
            o_wr_data_1      <= '0;
            o_pc_buf_ff      <= '0;
            o_irq            <= 1'b0;
            o_fiq            <= 1'b0;
            o_instr_abt      <= 1'b0;
            o_swi            <= 1'b0;
            o_und            <= 1'b0;
            o_data_abt       <= 1'b0;
        end else if (bubble) begin
            o_valid       <= 1'b0;
            o_mem_load_ff <= 1'b0;
            o_irq         <= 1'b0;
            o_fiq         <= 1'b0;
            o_instr_abt   <= 1'b0;
            o_swi         <= 1'b0;
            o_und         <= 1'b0;
            o_data_abt    <= 1'b0;
        end else begin
            o_valid          <= i_valid & ~load_abt;
            o_wr_index       <= i_wr_index;
            o_wr_data        <= i_alu_result;
            o_flags          <= i_flags;
            o_flag_update_ff <= i_flag_update;
            o_mem_load_ff    <= load_abt ? 1'b0 : (i_valid & i_mem_load);
            o_wr_index_1     <= i_mem_srcdest_index;
            o_wr_data_1      <= aligned;
            o_pc_buf_ff      <= i_pc_plus_8;
            o_irq            <= i_irq & i_valid;
            o_fiq            <= i_fiq & i_valid;
            o_instr_abt      <= i_instr_abt & i_valid;
            o_swi            <= i_swi & i_valid;
            o_und            <= i_und & i_valid;
            o_data_abt       <= load_abt;
        end
    end

endmodule

// File: tb/tb_zap_memory_main.sv
// tb/tb_zap_memory_main.sv - directed self-checking bench for zap_memory_main
module tb_zap_memory_main;
    import zap_memory_main_pkg::*;

    localparam int IDX = $clog2(46);

    logic            i_clk = 1'b0;
    logic            i_reset_n;
    logic            i_valid;
    logic [31:0]     i_alu_result;
    logic [IDX-1:0]  i_wr_index;
    logic [31:0]     i_flags;
    logic            i_flag_update;
    logic            i_mem_load;
    logic [IDX-1:0]  i_mem_srcdest_index;
    logic [1:0]      i_mem_size;
    logic            i_mem_signed;
    logic [1:0]      i_mem_addr_lsb;
    logic [31:0]     i_pc_plus_8;
    logic            i_irq, i_fiq, i_instr_abt, i_swi, i_und;
    logic [31:0]     i_data_rd;
    logic            i_data_stall;
    logic            i_data_abt;
    logic            i_clear_from_writeback;
    logic            o_valid;
    logic [IDX-1:0]  o_wr_index;
    logic [31:0]     o_wr_data;
    logic [31:0]     o_flags;
    logic            o_flag_update_ff;
    logic            o_mem_load_ff;
    logic [IDX-1:0]  o_wr_index_1;
    logic [31:0]     o_wr_data_1;
    logic [31:0]     o_pc_buf_ff;
    logic            o_irq, o_fiq, o_instr_abt, o_swi, o_und, o_data_abt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    zap_memory_main #(.PHY_REGS(46), .FLAG_WDT(32)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid),
        .i_alu_result(i_alu_result), .i_wr_index(i_wr_index), .i_flags(i_flags),
        .i_flag_update(i_flag_update), .i_mem_load(i_mem_load),
        .i_mem_srcdest_index(i_mem_srcdest_index), .i_mem_size(i_mem_size),
        .i_mem_signed(i_mem_signed), .i_mem_addr_lsb(i_mem_addr_lsb),
        .i_pc_plus_8(i_pc_plus_8), .i_irq(i_irq), .i_fiq(i_fiq),
        .i_instr_abt(i_instr_abt), .i_swi(i_swi), .i_und(i_und),
        .i_data_rd(i_data_rd), .i_data_stall(i_data_stall), .i_data_abt(i_data_abt),
        .i_clear_from_writeback(i_clear_from_writeback),
        .o_valid(o_valid), .o_wr_index(o_wr_index), .o_wr_data(o_wr_data),
        .o_flags(o_flags), .o_flag_update_ff(o_flag_update_ff),
        .o_mem_load_ff(o_mem_load_ff), .o_wr_index_1(o_wr_index_1),
        .o_wr_data_1(o_wr_data_1), .o_pc_buf_ff(o_pc_buf_ff),
        .o_irq(o_irq), .o_fiq(o_fiq), .o_instr_abt(o_instr_abt), .o_swi(o_swi),
        .o_und(o_und), .o_data_abt(o_data_abt)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_alu_result = 0; i_wr_index = 0; i_flags = 0; i_flag_update = 0;
        i_mem_load = 0; i_mem_srcdest_index = 0; i_mem_size = MEM_WORD; i_mem_signed = 0;
        i_mem_addr_lsb = 0; i_pc_plus_8 = 0; i_irq = 0; i_fiq = 0; i_instr_abt = 0;
        i_swi = 0; i_und = 0; i_data_rd = 0; i_data_stall = 0; i_data_abt = 0;
        i_clear_from_writeback = 0;
    endtask

    task automatic test_reset();
        i_reset_n = 1;
        idle_inputs();
        i_valid = 1; i_alu_result = 32'h55; i_wr_index = 6'd7;
        step();
        #2 i_reset_n = 0;
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0h exp=0", o_valid); end
        n_cmp++; if (o_wr_index !== 6'd45) begin n_bad++; $display("FAIL reset_wr_index got=%0d exp=45", o_wr_index); end
        n_cmp++; if (o_wr_index_1 !== 6'd45) begin n_bad++; $display("FAIL reset_wr_index_1 got=%0d exp=45", o_wr_index_1); end
        n_cmp++; if ({o_wr_data, o_wr_data_1, o_pc_buf_ff, o_flags} !== 128'h0) begin n_bad++; $display("FAIL reset_data got=%0h exp=0", {o_wr_data, o_wr_data_1, o_pc_buf_ff, o_flags}); end
        n_cmp++; if ({o_mem_load_ff, o_flag_update_ff, o_irq, o_fiq, o_instr_abt, o_swi, o_und, o_data_abt} !== 8'h0) begin n_bad++; $display("FAIL reset_flags got=%0h exp=0", {o_mem_load_ff, o_flag_update_ff, o_irq, o_fiq, o_instr_abt, o_swi, o_und, o_data_abt}); end
        @(negedge i_clk);
        idle_inputs();
        i_reset_n = 1;
        step();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid got=%0h exp=0", o_valid); end
    endtask

    task automatic test_loads();
        logic [1:0]  sizes [4] = '{MEM_BYTE, MEM_BYTE, MEM_HALF, MEM_WORD};
        logic        sgn   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0]  offs  [4] = '{2'd1, 2'd2, 2'd2, 2'd1};
        logic [31:0] exps  [4] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000080FF, 32'h0180FF7F};
        idle_inputs();
        i_valid = 1; i_mem_load = 1; i_data_rd = 32'h80FF7F01; i_mem_srcdest_index = 6'd4;
        for (int k = 0; k < 4; k++) begin
            i_mem_size = sizes[k]; i_mem_signed = sgn[k]; i_mem_addr_lsb = offs[k];
            step();
            n_cmp++; if (o_wr_data_1 !== exps[k]) begin n_bad++; $display("FAIL load_align_%0d got=%08h exp=%08h", k, o_wr_data_1, exps[k]); end
        end
        n_cmp++; if (o_mem_load_ff !== 1'b1 || o_wr_index_1 !== 6'd4 || o_valid !== 1'b1) begin n_bad++; $display("FAIL load_ctrl got=%0b/%0d/%0b exp=1/4/1", o_mem_load_ff, o_wr_index_1, o_valid); end
        i_mem_size = 2'd3; i_mem_addr_lsb = 2'd3;
        step();
        n_cmp++; if (o_wr_data_1 !== 32'hFF7F0180) begin n_bad++; $display("FAIL load_reserved_size got=%08h exp=ff7f0180", o_wr_data_1); end
    endtask

    task automatic test_stall();
        idle_inputs();
        i_valid = 1; i_alu_result = 32'd5; i_wr_index = 6'd3;
        step();
        n_cmp++; if (o_valid !== 1'b1 || o_wr_data !== 32'd5) begin n_bad++; $display("FAIL stall_capture got=%0b/%0d exp=1/5", o_valid, o_wr_data); end
        i_data_stall = 1; i_alu_result = 32'd9; i_irq = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (o_valid !== 1'b0 || o_irq !== 1'b0) begin n_bad++; $display("FAIL stall_bubble_%0d got=%0b/%0b exp=0/0", k, o_valid, o_irq); end
            n_cmp++; if (o_wr_data !== 32'd5 || o_wr_index !== 6'd3) begin n_bad++; $display("FAIL stall_hold_%0d got=%0d/%0d exp=5/3", k, o_wr_data, o_wr_index); end
        end
        i_data_stall = 0; i_irq = 0;
        step();
        n_cmp++; if (o_valid !== 1'b1 || o_wr_data !== 32'd9) begin n_bad++; $display("FAIL stall_release got=%0b/%0d exp=1/9", o_valid, o_wr_data); end
    endtask

    task automatic test_flush();
        idle_inputs();
        i_valid = 1; i_irq = 1; i_mem_load = 1; i_alu_result = 32'h77;
        i_clear_from_writeback = 1; i_data_stall = 1;
        step();
        n_cmp++; if (o_valid !== 1'b0 || o_irq !== 1'b0 || o_mem_load_ff !== 1'b0) begin n_bad++; $display("FAIL flush_stall got=%0b/%0b/%0b exp=0/0/0", o_valid, o_irq, o_mem_load_ff); end
        i_data_stall = 0;
        step();
        n_cmp++; if (o_valid !== 1'b0 || o_irq !== 1'b0) begin n_bad++; $display("FAIL flush_only got=%0b/%0b exp=0/0", o_valid, o_irq); end
    endtask

    task automatic test_abort();
        idle_inputs();
        i_valid = 1; i_mem_load = 1; i_data_abt = 1;
        step();
        n_cmp++; if (o_data_abt !== 1'b1 || o_valid !== 1'b0 || o_mem_load_ff !== 1'b0) begin n_bad++; $display("FAIL abort_load got=%0b/%0b/%0b exp=1/0/0", o_data_abt, o_valid, o_mem_load_ff); end
        i_mem_load = 0;
        step();
        n_cmp++; if (o_data_abt !== 1'b0 || o_valid !== 1'b1 || o_mem_load_ff !== 1'b0) begin n_bad++; $display("FAIL abort_store got=%0b/%0b/%0b exp=0/1/0", o_data_abt, o_valid, o_mem_load_ff); end
    endtask

    task automatic test_exceptions();
        idle_inputs();
        i_valid = 1; i_swi = 1; i_pc_plus_8 = 32'h108; i_flags = 32'hA000_0010; i_flag_update = 1;
        step();
        n_cmp++; if (o_swi !== 1'b1 || o_pc_buf_ff !== 32'h108) begin n_bad++; $display("FAIL swi_valid got=%0b/%0h exp=1/108", o_swi, o_pc_buf_ff); end
        n_cmp++; if (o_flags !== 32'hA000_0010 || o_flag_update_ff !== 1'b1) begin n_bad++; $display("FAIL flags got=%08h/%0b exp=a0000010/1", o_flags, o_flag_update_ff); end
        i_valid = 0; i_fiq = 1; i_und = 1; i_instr_abt = 1;
        step();
        n_cmp++; if ({o_swi, o_fiq, o_und, o_instr_abt} !== 4'b0) begin n_bad++; $display("FAIL exc_invalid got=%04b exp=0000", {o_swi, o_fiq, o_und, o_instr_abt}); end
        i_valid = 1;
        step();
        n_cmp++; if ({o_swi, o_fiq, o_und, o_instr_abt} !== 4'b1111) begin n_bad++; $display("FAIL exc_valid got=%04b exp=1111", {o_swi, o_fiq, o_und, o_instr_abt}); end
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        i_valid = 1; i_data_stall = 1;
        step();
        #2 i_reset_n = 0;
        #1;
        n_cmp++; if (o_valid !== 1'b0 || o_wr_index !== 6'd45) begin n_bad++; $display("FAIL reset_stall got=%0b/%0d exp=0/45", o_valid, o_wr_index); end
        @(negedge i_clk);
        i_reset_n = 1;
        step();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_stall_first got=%0b exp=0", o_valid); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stall();
        test_flush();
        test_abort();
        test_exceptions();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
